acc_resp_buffer: RTL

Buffers accelerator responses between the accelerator interface and the CVA6 writeback path. It also tracks dispatched-but-unretired accelerator requests, and gates new requests so that every outstanding request is guaranteed a buffer slot. It sits downstream of the accelerator dispatcher's request register, observing its request handshake. It sits upstream of the scoreboard writeback port, which may backpressure.

---
 rtl/acc_pkg.sv | 24 ++
 rtl/config_pkg.sv | 12 +
 rtl/fifo_v3.sv | 52 +++++
 rtl/acc_resp_buffer.sv | 118 +++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Accelerator writeback types shared by the response buffer and its users.
package acc_pkg;

  localparam int unsigned XLEN               = config_pkg::cva6_cfg_empty.XLEN;
  localparam int unsigned TRANS_ID_BITS      = config_pkg::cva6_cfg_empty.TRANS_ID_BITS;
  localparam int unsigned ACC_RESP_BUF_DEPTH = 4;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = XLEN'(2);

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     error;
    logic                     fflags_valid;
    logic [4:0]               fflags;
  } acc_wb_t;

endpackage

// File: rtl/config_pkg.sv
// Minimal core-configuration package: only the fields the accelerator
// response path needs to size its ports.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, TRANS_ID_BITS: 3};

endpackage

// File: rtl/fifo_v3.sv
// Small in-order FIFO with optional fall-through: when empty, a pushed word is
// visible on data_o in the same cycle and is not stored if popped at once.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             bypass, do_push, do_pop;

  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
      if (do_push != do_pop) cnt_q <= do_push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: data_o is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/acc_resp_buffer.sv
// Accelerator response buffer with outstanding-request gating toward the
// dispatcher. Define ACC_RESP_BUF_BYPASS_EN for same-cycle fall-through.
module acc_resp_buffer
  import acc_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           Depth   = ACC_RESP_BUF_DEPTH,
  parameter int unsigned           CntW    = $clog2(Depth + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             acc_req_valid_i,
  input  logic                             acc_req_ready_i,
  output logic                             acc_req_gate_o,
  input  logic                             acc_resp_valid_i,
  output logic                             acc_resp_ready_o,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0] acc_resp_trans_id_i,
  input  logic [CVA6Cfg.XLEN-1:0]          acc_resp_result_i,
  input  logic                             acc_resp_error_i,
  input  logic                             acc_resp_fflags_valid_i,
  input  logic [4:0]                       acc_resp_fflags_i,
  output logic                             wb_valid_o,
  input  logic                             wb_ready_i,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CVA6Cfg.XLEN-1:0]          wb_result_o,
  output exception_t                       wb_exception_o,
  output logic                             wb_fflags_valid_o,
  output logic [4:0]                       wb_fflags_o,
  output logic [CntW-1:0]                  outstanding_o,
  output logic                             overflow_o
);

`ifdef ACC_RESP_BUF_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  localparam logic [CntW-1:0] MaxCnt = CntW'(Depth);

  acc_wb_t         resp_in, head;
  logic            fifo_full, fifo_empty;
  logic            issue, wb_fire;
  logic [CntW-1:0] cnt_q;
  logic            overflow_q;

  assign resp_in = '{
    trans_id:     acc_resp_trans_id_i,
    result:       acc_resp_result_i,
    error:        acc_resp_error_i,
    fflags_valid: acc_resp_fflags_valid_i,
    fflags:       acc_resp_fflags_i
  };

  fifo_v3 #(
    .FALL_THROUGH(BypassEn),
    .DEPTH       (Depth),
    .dtype       (acc_wb_t)
  ) i_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .data_i (resp_in),
    .push_i (acc_resp_valid_i & ~fifo_full),
    .data_o (head),
    .pop_i  (wb_fire)
  );

  assign acc_resp_ready_o = ~fifo_full;
  assign wb_valid_o       = ~fifo_empty;
  assign issue            = acc_req_valid_i & acc_req_ready_i;
  assign wb_fire          = wb_valid_o & wb_ready_i;

  // Gate on the registered count only, so wb_ready_i never reaches the dispatcher.
  assign acc_req_gate_o = (cnt_q < MaxCnt);
  assign outstanding_o  = cnt_q;
  assign overflow_o     = overflow_q;

  always_comb begin
    wb_trans_id_o     = '0;
    wb_result_o       = '0;
    wb_exception_o    = '0;
    wb_fflags_valid_o = 1'b0;
    wb_fflags_o       = '0;
    if (wb_valid_o) begin
      wb_trans_id_o        = head.trans_id;
      wb_result_o          = head.result;
      wb_exception_o.cause = ILLEGAL_INSTR;
      wb_exception_o.tval  = '0;
      wb_exception_o.valid = head.error;
      wb_fflags_valid_o    = head.fflags_valid;
      wb_fflags_o          = head.fflags;
    end
  end

  // Count until writeback (not response) so every in-flight response has a slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (acc_resp_valid_i && fifo_full) overflow_q <= 1'b1;
      case ({issue, wb_fire})
        2'b10: begin
          if (cnt_q == MaxCnt) overflow_q <= 1'b1;
          else                 cnt_q      <= cnt_q + 1'b1;
        end
        2'b01: begin
          if (cnt_q == '0) overflow_q <= 1'b1;
          else             cnt_q      <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
